instr_stream_encoder: RTL and testbench

Sequential RV32I instruction encoder and instruction-memory loader for the pipelined core's bring-up path. Accepts field-level instruction requests (kind, registers, funct3/funct7, signed immediate) over a valid/ready handshake, packs each into a 32-bit RV32I word, and writes the words to consecutive instruction-memory addresses. It is the producing end of the encoding that the core's main decoder consumes, covering the same opcode set: R, I-ALU, LOAD, STORE, BRANCH, JAL.

---
 rtl/instr_stream_encoder_pkg.sv | 31 +++
 rtl/instr_field_encoder.sv | 67 ++++++
 rtl/instr_stream_encoder.sv | 128 ++++++++++++
 tb/tb_instr_stream_encoder.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_stream_encoder_pkg.sv
// Shared RV32I encoding definitions: instruction kinds, opcodes, NOP word and
// loader FSM states.
package rv32_encoder_pkg;

    typedef enum logic [2:0] {
        KIND_R      = 3'd0,
        KIND_I      = 3'd1,
        KIND_LOAD   = 3'd2,
        KIND_STORE  = 3'd3,
        KIND_BRANCH = 3'd4,
        KIND_JAL    = 3'd5
    } instr_kind_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } fsm_state_e;

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational RV32I packer: turns kind/fields/immediate into a 32-bit word and
// reports whether the immediate (and kind) is encodable; otherwise emits NOP.
module instr_field_encoder
    import rv32_encoder_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        imm_ok_o
);

    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic [31:0] raw_word;
    logic        raw_ok;

    // A value fits an N-bit signed field when all bits above N-1 equal the sign bit.
    assign fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign fits21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

    always_comb begin
        raw_word = NOP_WORD;
        raw_ok   = 1'b0;
        case (kind_i)
            KIND_R: begin
                raw_ok   = 1'b1;
                raw_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
            end
            KIND_I: begin
                raw_ok   = fits12;
                raw_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
            end
            KIND_LOAD: begin
                raw_ok   = fits12;
                raw_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
            end
            KIND_STORE: begin
                raw_ok   = fits12;
                raw_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
            end
            KIND_BRANCH: begin
                raw_ok   = fits13 & ~imm_i[0];
                raw_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], OP_BRANCH};
            end
            KIND_JAL: begin
                raw_ok   = fits21 & ~imm_i[0];
                raw_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
            end
            default: begin
                raw_ok   = 1'b0;
                raw_word = NOP_WORD;
            end
        endcase
    end

    assign imm_ok_o = raw_ok;
    assign word_o   = raw_ok ? raw_word : NOP_WORD;

endmodule

// File: rtl/instr_stream_encoder.sv
// Program loader: accepts field-level requests one at a time, encodes them and
// writes the words to consecutive instruction-memory addresses.
module instr_stream_encoder
    import rv32_encoder_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       prog_len,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [31:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        state_dbg
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in ACCEPT, so at most one request per two cycles.

    fsm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       count_q, count_d;
    logic              err_q, err_d;
    logic [31:0]       enc_word;
    logic              enc_ok;

    instr_field_encoder u_field_enc (
        .kind_i   (req_kind),
        .rd_i     (req_rd),
        .rs1_i    (req_rs1),
        .rs2_i    (req_rs2),
        .funct3_i (req_funct3),
        .funct7_i (req_funct7),
        .imm_i    (req_imm),
        .word_o   (enc_word),
        .imm_ok_o (enc_ok)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        len_d   = len_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = base_addr & ~ADDR_W'(3);
                    len_d   = prog_len;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = (prog_len == 16'd0) ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (req_valid) begin
                    wdata_d = enc_word;
                    waddr_d = addr_q;
                    // err becomes visible in the WRITE cycle of the substituted NOP
                    if (!enc_ok) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_W'(4);
                count_d = count_q + 16'd1;
                state_d = (count_q + 16'd1 == len_q) ? ST_DONE : ST_ACCEPT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            len_q   <= len_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_ACCEPT);
    assign imem_we    = (state_q == ST_WRITE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Self-checking bench for instr_stream_encoder: directed scenarios plus random
// program loads compared against an arithmetic RV32I encoding model.
module tb_instr_stream_encoder;

    localparam int ADDR_W = 32;
    localparam int WAIT_MAX = 50;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [15:0]       prog_len = '0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_kind = '0;
    logic [4:0]        req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [2:0]        req_funct3 = '0;
    logic [6:0]        req_funct7 = '0;
    logic [31:0]       req_imm = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy, done, err;
    logic [1:0]        state_dbg;

    instr_stream_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .prog_len   (prog_len),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_imm    (req_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_addr = '0;
    logic        exp_err = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] field(input logic [31:0] v, input int hi, input int lo);
        return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    function automatic logic [31:0] ref_encode(input int kind, input logic [31:0] rd,
                                               input logic [31:0] rs1, input logic [31:0] rs2,
                                               input logic [31:0] f3, input logic [31:0] f7,
                                               input int imm, output bit ok);
        logic [31:0] u;
        logic [31:0] w;
        u  = imm;
        w  = 32'h13;
        ok = 1'b0;
        case (kind)
            0: begin
                ok = 1'b1;
                w  = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            end
            1, 2: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w  = (field(u, 11, 0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7)
                     | ((kind == 1) ? 32'h13 : 32'h03);
            end
            3: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w  = (field(u, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                     | (field(u, 4, 0) << 7) | 32'h23;
            end
            4: begin
                ok = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
                w  = (field(u, 12, 12) << 31) | (field(u, 10, 5) << 25) | (rs2 << 20)
                     | (rs1 << 15) | (f3 << 12) | (field(u, 4, 1) << 8)
                     | (field(u, 11, 11) << 7) | 32'h63;
            end
            5: begin
                ok = (imm >= -(1 << 20)) && (imm <= (1 << 20) - 2) && (imm % 2 == 0);
                w  = (field(u, 20, 20) << 31) | (field(u, 10, 1) << 21)
                     | (field(u, 11, 11) << 20) | (field(u, 19, 12) << 12) | (rd << 7) | 32'h6F;
            end
            default: ok = 1'b0;
        endcase
        return ok ? w : 32'h13;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_load(input logic [31:0] base, input int len);
        start     = 1'b1;
        base_addr = base;
        prog_len  = 16'(len);
        @(negedge clk);
        start     = 1'b0;
        exp_addr  = base & ~32'd3;
        exp_err   = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            n_err++;
            $display("FAIL start_load: busy=%b err=%b, required busy=1 err=0", busy, err);
        end
    endtask

    // Issue one request, wait for its WRITE cycle and check the write there.
    task automatic do_req(input int kind, input int rd, input int rs1, input int rs2,
                          input int f3, input int f7, input int imm,
                          input logic [31:0] exp_word, input bit exp_ok, input int gap);
        int n;
        logic [31:0] ed, ea;
        repeat (gap) @(negedge clk);
        exp_q.push_back(exp_word);
        exp_addr_q.push_back(exp_addr);
        req_kind   = 3'(kind);
        req_rd     = 5'(rd);
        req_rs1    = 5'(rs1);
        req_rs2    = 5'(rs2);
        req_funct3 = 3'(f3);
        req_funct7 = 7'(f7);
        req_imm    = imm;
        req_valid  = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n >= WAIT_MAX) begin
            n_err++;
            $display("FAIL req_ready_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
            req_valid = 1'b0;
            void'(exp_q.pop_front());
            void'(exp_addr_q.pop_front());
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (!exp_ok) exp_err = 1'b1;
        ed = exp_q.pop_front();
        ea = exp_addr_q.pop_front();
        n_vec++;
        if (imem_we !== 1'b1 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL write_strobe: imem_we=%b req_ready=%b, required 1/0", imem_we, req_ready);
        end
        n_vec++;
        if (imem_wdata !== ed) begin
            n_err++;
            $display("FAIL write_data: got %08h required %08h (kind %0d imm %0d)", imem_wdata, ed, kind, imm);
        end
        n_vec++;
        if (imem_addr !== ea) begin
            n_err++;
            $display("FAIL write_addr: got %08h required %08h", imem_addr, ea);
        end
        n_vec++;
        if (err !== exp_err) begin
            n_err++;
            $display("FAIL err_flag: got %b required %b", err, exp_err);
        end
        last_addr = ea;
        last_data = ed;
        exp_addr  = exp_addr + 32'd4;
    endtask

    // Called at the negedge of the last WRITE cycle.
    task automatic check_done();
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || imem_we !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL done_pulse: done=%b we=%b busy=%b, required 1/0/1", done, imem_we, busy);
        end
        n_vec++;
        if (err !== exp_err) begin
            n_err++;
            $display("FAIL err_at_done: got %b required %b", err, exp_err);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_clear: done=%b busy=%b, required 0/0", done, busy);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if ({req_ready, imem_we, busy, done, err} !== 5'b0 || imem_addr !== '0
            || imem_wdata !== '0 || state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL %s: ready=%b we=%b busy=%b done=%b err=%b addr=%08h data=%08h st=%0d, required all 0",
                     tag, req_ready, imem_we, busy, done, err, imem_addr, imem_wdata, state_dbg);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_single_r();
        start_load(32'h100, 1);
        do_req(0, 3, 1, 2, 0, 0, 0, 32'h002081B3, 1'b1, 0);
        check_done();
    endtask

    task automatic test_table();
        start_load(32'h200, 4);
        do_req(1, 5, 0, 0, 0, 0, -1, 32'hFFF00293, 1'b1, 0);
        do_req(3, 0, 1, 2, 2, 0, 8, 32'h0020A423, 1'b1, 0);
        do_req(4, 0, 1, 2, 0, 0, -4, 32'hFE208EE3, 1'b1, 0);
        do_req(5, 1, 0, 0, 0, 0, 8, 32'h008000EF, 1'b1, 1);
        check_done();
    endtask

    task automatic test_illegal();
        start_load(32'h300, 4);
        do_req(1, 1, 2, 0, 0, 0, 2048, 32'h00000013, 1'b0, 0);
        do_req(4, 0, 1, 2, 0, 0, 3, 32'h00000013, 1'b0, 0);
        do_req(6, 1, 1, 1, 0, 0, 0, 32'h00000013, 1'b0, 0);
        do_req(0, 3, 1, 2, 0, 0, 0, 32'h002081B3, 1'b1, 0);
        check_done();
    endtask

    task automatic test_zero_len();
        start_load(32'h0, 0);
        n_vec++;
        if (done !== 1'b1 || imem_we !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len_done: done=%b we=%b, required 1/0", done, imem_we);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || imem_we !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len_idle: done=%b busy=%b we=%b, required 0/0/0", done, busy, imem_we);
        end
    endtask

    task automatic test_stall_and_start();
        start_load(32'h400, 2);
        start     = 1'b1;
        base_addr = 32'h700;
        prog_len  = 16'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (imem_we !== 1'b0 || req_ready !== 1'b1 || imem_addr !== last_addr
                || imem_wdata !== last_data) begin
                n_err++;
                $display("FAIL stall_cycle%0d: we=%b ready=%b addr=%08h data=%08h, required 0/1/%08h/%08h",
                         i, imem_we, req_ready, imem_addr, imem_wdata, last_addr, last_data);
            end
        end
        do_req(2, 7, 8, 0, 2, 0, -2048, 32'h80042383, 1'b1, 0);
        start = 1'b0;
        do_req(0, 9, 10, 11, 5, 32, 0, 32'h40B554B3, 1'b1, 0);
        check_done();
    endtask

    task automatic test_reset_mid_load();
        start_load(32'h500, 3);
        do_req(4, 0, 1, 2, 0, 0, 5, 32'h00000013, 1'b0, 0);
        do_req(0, 3, 1, 2, 0, 0, 0, 32'h002081B3, 1'b1, 0);
        rst       = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_mid_load");
        rst = 1'b0;
        begin
            int we_seen;
            we_seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (imem_we !== 1'b0 || busy !== 1'b0) we_seen++;
            end
            n_vec++;
            if (we_seen != 0) begin
                n_err++;
                $display("FAIL post_reset_quiet: %0d active cycles, required 0", we_seen);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [31:0] base;
            int len;
            base = (it == 3) ? 32'hFFFF_FFF6 : ($urandom & 32'h0000_FFFF);
            len  = (it == 3) ? 5 : $urandom_range(1, 8);
            start_load(base, len);
            for (int k = 0; k < len; k++) begin
                int kind, imm, rd, rs1, rs2, f3, f7, mode;
                bit ok;
                logic [31:0] w;
                int edge_vals[12] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                                      1048574, -1048576, 1048576, -1048578};
                kind = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
                rd   = $urandom_range(0, 31);
                rs1  = $urandom_range(0, 31);
                rs2  = $urandom_range(0, 31);
                f3   = $urandom_range(0, 7);
                f7   = $urandom_range(0, 127);
                mode = $urandom_range(0, 3);
                case (mode)
                    0: imm = int'($urandom_range(0, 4095)) - 2048;
                    1: imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
                    2: imm = int'($urandom_range(0, 4194303)) - 2097152;
                    default: imm = edge_vals[$urandom_range(0, 11)];
                endcase
                w = ref_encode(kind, rd, rs1, rs2, f3, f7, imm, ok);
                do_req(kind, rd, rs1, rs2, f3, f7, imm, w, ok, $urandom_range(0, 2));
            end
            check_done();
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_single_r();
        test_table();
        test_illegal();
        test_zero_len();
        test_stall_and_start();
        test_reset_mid_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
